// File: rtl/switch_allocator_pkg.sv
// Shared definitions for the mesh router switch allocator: port ordering,
// default port counts, the packet descriptor and a round-robin helper.
package switch_allocator_pkg;

    // Port ordering shared by inputs and outputs.
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    // Default router radix.
    localparam int N_PORTS = 5;
    localparam int M_PORTS = 5;

    // Head-flit descriptor as seen by the routing/selection stage.
    typedef struct packed {
        logic        ant;
        logic [2:0]  dst_port;
        logic [31:0] payload;
    } packet_t;

    // Next round-robin pointer after a winner: one past it, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Two-class round-robin pick: a one-hot grant from the high-class requests
// if any exist, otherwise from the low-class ones, scanning from ptr upward.
module rr_arbiter
    import switch_allocator_pkg::*;
#(
    parameter int N     = N_PORTS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     req_hi,
    input  logic [N-1:0]     req_lo,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_val
);

    logic [N-1:0]     pick_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    assign pick_s = (|req_hi) ? req_hi : req_lo;

    // Scan the chosen class starting at the pointer and take the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = IDX_W'((int'(ptr) + i) % N);
            if (!found_s && pick_s[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        gnt_val = found_s;
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-cycle switch allocator for one mesh router. Outputs are served in
// fixed order; each picks among unmasked requesters with class priority
// starving > ant > normal and round-robin order inside a class.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int N            = N_PORTS,
    parameter int M            = M_PORTS,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [0:N-1][0:M-1]               i_req,
    input  logic [0:N-1]                      i_ant,
    input  logic [0:M-1]                      i_en,
    output logic [0:N-1][0:M-1]               o_grant,
    output logic [0:N-1]                      o_en,
    output logic [0:M-1][$clog2(N)-1:0]       o_sel,
    output logic [0:M-1]                      o_sel_val
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [IDX_W-1:0] rr_ptr_r     [M];
    logic [CNT_W-1:0] starve_cnt_r [N];

    logic [N-1:0]     starving_s;
    logic [N-1:0]     ant_s;
    logic [N-1:0]     req_any_s;
    logic [N-1:0]     en_s;
    logic [N-1:0]     col_s        [M];
    logic [IDX_W-1:0] win_idx_s    [M];
    logic             win_val_s    [M];

    // Per-input status: starving flag, ant class and whether any request is up.
    always_comb begin
        starving_s = '0;
        ant_s      = '0;
        req_any_s  = '0;
        for (int n = 0; n < N; n++) begin
            starving_s[n] = (starve_cnt_r[n] >= CNT_W'(STARVE_LIMIT));
            ant_s[n]      = i_ant[n];
            req_any_s[n]  = |i_req[n];
        end
    end

    for (genvar m = 0; m < M; m++) begin : gen_out
        logic [N-1:0]     mask_in_s;
        logic [N-1:0]     mask_out_s;
        logic [N-1:0]     cand_s;
        logic [N-1:0]     starve_c_s;
        logic [N-1:0]     ant_c_s;
        logic [N-1:0]     norm_c_s;
        logic [N-1:0]     gnt_a_s;
        logic [N-1:0]     gnt_b_s;
        logic [IDX_W-1:0] idx_a_s;
        logic [IDX_W-1:0] idx_b_s;
        logic             val_a_s;
        logic             val_b_s;

        // Inputs already won by a lower-numbered output are masked here.
        if (m == 0) begin : g_first
            assign mask_in_s = '0;
        end else begin : g_chain
            assign mask_in_s = gen_out[m-1].mask_out_s;
        end

        // Candidates: requesting this output, output free downstream, not yet matched.
        always_comb begin
            cand_s = '0;
            for (int n = 0; n < N; n++) begin
                cand_s[n] = i_req[n][m] & i_en[m] & ~mask_in_s[n];
            end
        end

        assign starve_c_s = cand_s & starving_s;
        assign ant_c_s    = cand_s & ~starving_s & ant_s;
        assign norm_c_s   = cand_s & ~starving_s & ~ant_s;

        rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb_starve (
            .ptr     (rr_ptr_r[m]),
            .req_hi  (starve_c_s),
            .req_lo  ({N{1'b0}}),
            .gnt     (gnt_a_s),
            .gnt_idx (idx_a_s),
            .gnt_val (val_a_s)
        );

        rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb_ant (
            .ptr     (rr_ptr_r[m]),
            .req_hi  (ant_c_s),
            .req_lo  (norm_c_s),
            .gnt     (gnt_b_s),
            .gnt_idx (idx_b_s),
            .gnt_val (val_b_s)
        );

        // Starving requesters override the ant/normal pick.
        assign col_s[m]     = val_a_s ? gnt_a_s : gnt_b_s;
        assign win_idx_s[m] = val_a_s ? idx_a_s : idx_b_s;
        assign win_val_s[m] = val_a_s | val_b_s;
        assign mask_out_s   = mask_in_s | col_s[m];
    end

    // Row OR of the grant matrix: which inputs pop this cycle.
    always_comb begin
        en_s = '0;
        for (int m = 0; m < M; m++) begin
            en_s = en_s | col_s[m];
        end
    end

    // Drive the external view; everything is held at zero while in reset.
    always_comb begin
        o_grant   = '0;
        o_en      = '0;
        o_sel     = '0;
        o_sel_val = '0;
        if (reset_n) begin
            for (int m = 0; m < M; m++) begin
                o_sel_val[m] = win_val_s[m];
                o_sel[m]     = win_val_s[m] ? win_idx_s[m] : '0;
                for (int n = 0; n < N; n++) begin
                    o_grant[n][m] = col_s[m][n];
                end
            end
            for (int n = 0; n < N; n++) begin
                o_en[n] = en_s[n];
            end
        end else begin
            o_en = '0;
        end
    end

    // Round-robin pointers move one past the winner of each granted output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < M; m++) begin
                rr_ptr_r[m] <= '0;
            end
        end else begin
            for (int m = 0; m < M; m++) begin
                if (win_val_s[m]) begin
                    rr_ptr_r[m] <= IDX_W'(rr_next(int'(win_idx_s[m]), N));
                end else begin
                    rr_ptr_r[m] <= rr_ptr_r[m];
                end
            end
        end
    end

    // Starvation counters: count ungranted request cycles, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < N; n++) begin
                starve_cnt_r[n] <= '0;
            end
        end else begin
            for (int n = 0; n < N; n++) begin
                if (en_s[n] || !req_any_s[n]) begin
                    starve_cnt_r[n] <= '0;
                end else if (starve_cnt_r[n] < CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt_r[n] <= starve_cnt_r[n] + CNT_W'(1);
                end else begin
                    starve_cnt_r[n] <= starve_cnt_r[n];
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios followed by random traffic,
// every cycle compared against a behavioural allocation model.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam int N   = 5;
    localparam int M   = 5;
    localparam int LIM = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [0:N-1][0:M-1]     i_req;
    logic [0:N-1]            i_ant;
    logic [0:M-1]            i_en;
    logic [0:N-1][0:M-1]     o_grant;
    logic [0:N-1]            o_en;
    logic [0:M-1][2:0]       o_sel;
    logic [0:M-1]            o_sel_val;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m [M];
    int cnt_m [N];
    int exp_win [M];

    switch_allocator #(.N(N), .M(M), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_ant     (i_ant),
        .i_en      (i_en),
        .o_grant   (o_grant),
        .o_en      (o_en),
        .o_sel     (o_sel),
        .o_sel_val (o_sel_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < M; m++) ptr_m[m] = 0;
        for (int n = 0; n < N; n++) cnt_m[n] = 0;
    endfunction

    // For each free output in order, take the best class among unmatched
    // requesters; ties go to whoever comes first from the pointer.
    function automatic void model_eval();
        bit used [N];
        int best, bc, c, n;
        for (int m = 0; m < M; m++) exp_win[m] = -1;
        for (int k = 0; k < N; k++) used[k] = 1'b0;
        if (reset_n === 1'b1) begin
            for (int m = 0; m < M; m++) begin
                if (i_en[m]) begin
                    best = -1;
                    bc   = -1;
                    for (int k = 0; k < N; k++) begin
                        n = (ptr_m[m] + k) % N;
                        if (i_req[n][m] && !used[n]) begin
                            c = (cnt_m[n] >= LIM) ? 2 : (i_ant[n] ? 1 : 0);
                            if (c > bc) begin
                                bc   = c;
                                best = n;
                            end
                        end
                    end
                    exp_win[m] = best;
                    if (best >= 0) used[best] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_clock();
        bit granted;
        if (reset_n !== 1'b1) begin
            model_reset();
        end else begin
            for (int m = 0; m < M; m++)
                if (exp_win[m] >= 0) ptr_m[m] = (exp_win[m] + 1) % N;
            for (int n = 0; n < N; n++) begin
                granted = 1'b0;
                for (int m = 0; m < M; m++) if (exp_win[m] == n) granted = 1'b1;
                if (granted || i_req[n] == '0) cnt_m[n] = 0;
                else if (cnt_m[n] < LIM) cnt_m[n] = cnt_m[n] + 1;
            end
        end
    endfunction

    task automatic settle_check(input string tag);
        logic [0:N-1][0:M-1] eg;
        logic [0:N-1]        ee;
        logic [0:M-1]        ev;
        logic [14:0]         es, os;
        #2;
        model_eval();
        eg = '0; ee = '0; ev = '0; es = '0; os = '0;
        for (int m = 0; m < M; m++) begin
            if (exp_win[m] >= 0) begin
                eg[exp_win[m]][m] = 1'b1;
                ee[exp_win[m]]    = 1'b1;
                ev[m]             = 1'b1;
                es[m*3 +: 3]      = 3'(exp_win[m]);
                os[m*3 +: 3]      = o_sel[m];
            end
        end
        chk({tag, "_grant"}, 32'(o_grant), 32'(eg));
        chk({tag, "_en"}, 32'(o_en), 32'(ee));
        chk({tag, "_selval"}, 32'(o_sel_val), 32'(ev));
        chk({tag, "_sel"}, 32'(os), 32'(es));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic rand_inputs();
        for (int n = 0; n < N; n++) begin
            i_req[n] = ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom);
            i_ant[n] = ($urandom_range(0, 3) == 0);
        end
        for (int m = 0; m < M; m++) i_en[m] = ($urandom_range(0, 4) != 0);
    endtask

    initial begin
        int got, viol, cnt1;
        model_reset();
        reset_n = 1'b0;
        i_ant   = '0;
        i_en    = '1;

        // Reset and idle
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            settle_check("rst_hold");
            tick();
        end
        reset_n = 1'b1;
        i_req   = '0;
        i_ant   = '0;
        i_en    = '1;
        for (int k = 0; k < 2; k++) begin
            settle_check("idle");
            tick();
        end

        // Round-robin among inputs 1..3 on output 0
        i_req[NORTH][LOCAL] = 1'b1;
        i_req[EAST][LOCAL]  = 1'b1;
        i_req[SOUTH][LOCAL] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle_check("rr");
            chk("rr_seq", 32'(o_sel[0]), 32'((k % 3) + 1));
            tick();
        end

        // Ant priority on output 2
        i_req = '0;
        i_req[LOCAL][EAST] = 1'b1;
        i_req[WEST][EAST]  = 1'b1;
        i_ant[WEST]        = 1'b1;
        chk("ant_ptr_pre", 32'(dut.rr_ptr_r[2]), 32'd0);
        settle_check("ant");
        chk("ant_win", 32'(o_sel[2]), 32'd4);
        tick();
        chk("ant_ptr", 32'(dut.rr_ptr_r[2]), 32'd0);

        // Starvation: normal input 1 vs always-ready ant input 2 on output 3
        i_req = '0;
        i_ant = '0;
        settle_check("clear");
        tick();
        i_req[NORTH][SOUTH] = 1'b1;
        i_req[EAST][SOUTH]  = 1'b1;
        i_ant[EAST]         = 1'b1;
        got = 0;
        for (int c = 1; c <= 8 && got == 0; c++) begin
            settle_check("starve");
            if (o_grant[1][3] === 1'b1) got = c;
            tick();
        end
        chk("starve_cycle", 32'(got), 32'd5);
        cnt1 = int'(dut.starve_cnt_r[1]);
        chk("starve_clr", 32'(cnt1), 32'd0);

        // Adaptive request with a blocked output
        i_req = '0;
        i_ant = '0;
        i_req[0] = 5'b01100;
        i_req[1] = 5'b00100;
        i_en     = 5'b10111;
        settle_check("adapt");
        viol = 0;
        for (int n = 0; n < N; n++) begin
            if ($countones(o_grant[n]) > 1) viol++;
            if (o_en[n] !== (|o_grant[n])) viol++;
        end
        for (int m = 0; m < M; m++) begin
            got = 0;
            for (int n = 0; n < N; n++) if (o_grant[n][m]) got++;
            if (got > 1) viol++;
        end
        chk("adapt_rowcol", 32'(viol), 32'd0);
        chk("adapt_in0", 32'(o_grant[0]), 32'b00100);
        chk("adapt_in1", 32'(o_grant[1]), 32'b00000);
        tick();

        // Asynchronous reset in the middle of traffic
        for (int k = 0; k < 6; k++) begin
            rand_inputs();
            settle_check("pre_rst");
            tick();
        end
        i_en = '1;
        i_req[NORTH][LOCAL] = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 32'(o_grant), 32'd0);
        chk("arst_en", 32'(o_en), 32'd0);
        chk("arst_selval", 32'(o_sel_val), 32'd0);
        model_reset();
        settle_check("arst_hold");
        tick();
        reset_n = 1'b1;
        for (int m = 0; m < M; m++) chk("arst_ptr", 32'(dut.rr_ptr_r[m]), 32'd0);
        for (int n = 0; n < N; n++) chk("arst_cnt", 32'(dut.starve_cnt_r[n]), 32'd0);
        i_req = '0;
        i_ant = '0;
        i_req[NORTH][LOCAL] = 1'b1;
        i_req[EAST][LOCAL]  = 1'b1;
        settle_check("post_rst");
        chk("post_rst_sel", 32'(o_sel[0]), 32'd1);
        tick();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            settle_check("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
